// File: rtl/div_16_bit_seq_if.sv
// Request/response bundle for the sequential divider.
// DIV_SIGNED_EN adds the sgn request bit.
interface div_16_bit_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic             sgn;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
`ifdef DIV_SIGNED_EN
    output sgn,
`endif
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
`ifdef DIV_SIGNED_EN
    input  sgn,
`endif
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/div_16_bit_seq.sv
// 16-bit restoring divider, one quotient bit per clock, 16-cycle latency.
// Define DIV_SIGNED_EN for two's-complement truncating division selected by sgn.
module div_16_bit_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  div_16_bit_seq_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quot_fin;
  logic [WIDTH-1:0] rem_fin;

  // One restoring step: trial-subtract the divisor from the shifted-in partial remainder.
  always_comb begin
    trial  = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};
    borrow = trial[WIDTH];
    r_step = borrow ? {r_q[WIDTH-2:0], q_q[WIDTH-1]} : trial[WIDTH-1:0];
    q_step = {q_q[WIDTH-2:0], ~borrow};
  end

  assign accept    = bus.start && (state_q != StRun);
  assign last_iter = (cnt_q == 5'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
  logic a_neg, b_neg;

  always_comb begin
    a_neg    = bus.sgn & bus.dividend[WIDTH-1];
    b_neg    = bus.sgn & bus.divisor[WIDTH-1];
    a_mag    = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    b_mag    = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    quot_fin = neg_quot_q ? (~q_step + 1'b1) : q_step;
    rem_fin  = neg_rem_q ? (~r_step + 1'b1) : r_step;
  end

  always_comb begin
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (accept && (bus.divisor != '0)) begin
      neg_quot_d = a_neg ^ b_neg;
      neg_rem_d  = a_neg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end
`else
  always_comb begin
    a_mag    = bus.dividend;
    b_mag    = bus.divisor;
    quot_fin = q_step;
    rem_fin  = r_step;
  end
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StRun: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 5'd1;
        if (last_iter) begin
          quot_d  = quot_fin;
          rem_d   = rem_fin;
          state_d = StDone;
        end
      end
      default: begin
        // Idle and Done both accept a new request; Done otherwise falls back to Idle.
        state_d = StIdle;
        if (accept) begin
          if (bus.divisor == '0) begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            r_d     = '0;
            q_d     = a_mag;
            d_d     = b_mag;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = StRun;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == StRun);
  assign bus.done        = (state_q == StDone);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
